// File: rtl/sys1_input_pkg.sv
// Shared constants and types for the SEGA System 1 input conditioning stage.
// Joystick bit map, sysmode layout bits, layout and coin-FSM enums.
package sys1_input_pkg;

  localparam int JB_RIGHT  = 0;
  localparam int JB_LEFT   = 1;
  localparam int JB_DOWN   = 2;
  localparam int JB_UP     = 3;
  localparam int JB_TRIG1  = 4;
  localparam int JB_TRIG2  = 5;
  localparam int JB_TRIG3  = 6;
  localparam int JB_START1 = 9;
  localparam int JB_START2 = 10;
  localparam int JB_COIN   = 11;
  localparam int JB_PAUSE  = 12;

  localparam int SM_WMATCH  = 3;
  localparam int SM_SPINNER = 5;

  typedef enum logic [1:0] {
    LAYOUT_NORMAL,
    LAYOUT_WMATCH,
    LAYOUT_SPINNER
  } sys1_layout_e;

  typedef enum logic [1:0] {
    COIN_IDLE,
    COIN_ACTIVE,
    COIN_HOLD
  } coin_st_e;

  // Spinner wins over Water Match, which wins over the normal layout.
  function automatic sys1_layout_e layout_of(input logic wmatch, input logic spinner);
    if (spinner)     return LAYOUT_SPINNER;
    else if (wmatch) return LAYOUT_WMATCH;
    else             return LAYOUT_NORMAL;
  endfunction

endpackage

// File: rtl/sys1_input_ctrl_if.sv
// Core-facing bundle: active-low INP0/1/2 ports, pause request and video dim flag.
interface sys1_input_ctrl_if;
  logic [7:0] inp0;
  logic [7:0] inp1;
  logic [7:0] inp2;
  logic       pause;
  logic       dim;

  modport master (output inp0, inp1, inp2, pause, dim);
  modport slave  (input  inp0, inp1, inp2, pause, dim);
endinterface

// File: rtl/sys1_coin_shaper.sv
// Turns a (synchronised) coin switch into a pulse lasting COIN_FRAMES vs rising
// edges; the switch must be released before another pulse can start.
module sys1_coin_shaper
  import sys1_input_pkg::*;
#(
  parameter int COIN_FRAMES = 3
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic coin_in,
  input  logic vs_in,
  output logic coin_out
);

  localparam int CW = (COIN_FRAMES > 1) ? $clog2(COIN_FRAMES) : 1;
  localparam logic [CW-1:0] LAST = CW'(COIN_FRAMES - 1);

  coin_st_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          coin_d, vs_d;
  logic          coin_rise, vs_rise;

  assign coin_rise = coin_in & ~coin_d;
  assign vs_rise   = vs_in & ~vs_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= COIN_IDLE;
      cnt_q   <= '0;
      coin_d  <= 1'b0;
      vs_d    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      coin_d  <= coin_in;
      vs_d    <= vs_in;
    end
  end

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    coin_out = 1'b0;
    unique case (state_q)
      COIN_IDLE: begin
        // A vs edge coinciding with the press is deliberately ignored here.
        if (coin_rise) begin
          state_d = COIN_ACTIVE;
          cnt_d   = '0;
        end
      end
      COIN_ACTIVE: begin
        coin_out = 1'b1;
        if (vs_rise) begin
          if (cnt_q == LAST) state_d = COIN_HOLD;
          else               cnt_d   = cnt_q + 1'b1;
        end
      end
      COIN_HOLD: begin
        if (!coin_in) state_d = COIN_IDLE;
      end
      default: state_d = COIN_IDLE;
    endcase
  end

endmodule

// File: rtl/sys1_input_ctrl.sv
// SEGA System 1 input conditioning: control layout mux, coin shaping, pause and
// video dim. The dim timer is built only when SYS1_PAUSE_DIM_EN is defined.
module sys1_input_ctrl
  import sys1_input_pkg::*;
#(
  parameter int          COIN_FRAMES = 3,
  parameter logic [31:0] DIM_CYCLES  = 32'h1C9C3800
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [7:0]  sysmode,
  input  logic [15:0] joy,
  input  logic [15:0] joy1,
  input  logic [15:0] joy2,
  input  logic [7:0]  spin,
  input  logic [2:0]  mouse_btn,
  input  logic        vs,
  input  logic        hs_access,
  input  logic        osd_open,
  input  logic        pause_osd_en,
  sys1_input_ctrl_if.master core
);

  logic [15:0] joy_s1, joy_s2, joy1_s1, joy1_s2, joy2_s1, joy2_s2;
  logic [2:0]  mouse_s1, mouse_s2;
  logic        vs_s1, vs_s2, osd_s1, osd_s2;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      joy_s1   <= '0;  joy_s2   <= '0;
      joy1_s1  <= '0;  joy1_s2  <= '0;
      joy2_s1  <= '0;  joy2_s2  <= '0;
      mouse_s1 <= '0;  mouse_s2 <= '0;
      vs_s1    <= 1'b0; vs_s2   <= 1'b0;
      osd_s1   <= 1'b0; osd_s2  <= 1'b0;
    end else begin
      joy_s1   <= joy;       joy_s2   <= joy_s1;
      joy1_s1  <= joy1;      joy1_s2  <= joy1_s1;
      joy2_s1  <= joy2;      joy2_s2  <= joy2_s1;
      mouse_s1 <= mouse_btn; mouse_s2 <= mouse_s1;
      vs_s1    <= vs;        vs_s2    <= vs_s1;
      osd_s1   <= osd_open;  osd_s2   <= osd_s1;
    end
  end

  logic coin;

  sys1_coin_shaper #(.COIN_FRAMES(COIN_FRAMES)) u_coin (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .coin_in  (joy_s2[JB_COIN]),
    .vs_in    (vs_s2),
    .coin_out (coin)
  );

  sys1_layout_e layout;
  logic [3:0]   stick_l, stick_r;
  logic         start1, start2, trig_spin;
  logic [7:0]   pad_d, inp2_d, pad_q, inp2_q;

  assign layout    = layout_of(sysmode[SM_WMATCH], sysmode[SM_SPINNER]);
  assign stick_l   = joy1_s2[3:0];
  assign stick_r   = joy1_s2[7:4] | joy2_s2[3:0];
  assign start1    = joy_s2[JB_START1];
  assign start2    = joy_s2[JB_START2];
  assign trig_spin = joy_s2[JB_TRIG1] | (|mouse_s2);

  // Stick nibbles use the joystick order {U,D,L,R}.
  always_comb begin
    pad_d  = 8'hFF;
    inp2_d = 8'hFF;
    unique case (layout)
      LAYOUT_SPINNER: begin
        pad_d  = ~spin;
        inp2_d = ~{trig_spin, trig_spin, start2, start1, 3'b000, coin};
      end
      LAYOUT_WMATCH: begin
        pad_d  = ~{stick_l[JB_LEFT], stick_l[JB_RIGHT], stick_l[JB_UP], stick_l[JB_DOWN],
                   stick_r[JB_LEFT], stick_r[JB_RIGHT], stick_r[JB_UP], stick_r[JB_DOWN]};
        inp2_d = ~{joy1_s2[8], joy1_s2[8], start2, start1, 3'b000, coin};
      end
      default: begin
        pad_d  = ~{joy_s2[JB_LEFT], joy_s2[JB_RIGHT], joy_s2[JB_UP], joy_s2[JB_DOWN], 1'b0,
                   joy_s2[JB_TRIG2], joy_s2[JB_TRIG1], joy_s2[JB_TRIG3]};
        inp2_d = ~{2'b00, start2, start1, 3'b000, coin};
      end
    endcase
  end

  logic pause_d, pause_toggle, pause_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      pad_q        <= 8'hFF;
      inp2_q       <= 8'hFF;
      pause_d      <= 1'b0;
      pause_toggle <= 1'b0;
      pause_q      <= 1'b0;
    end else begin
      pad_q        <= pad_d;
      inp2_q       <= inp2_d;
      pause_d      <= joy_s2[JB_PAUSE];
      if (joy_s2[JB_PAUSE] && !pause_d) pause_toggle <= ~pause_toggle;
      pause_q      <= hs_access | pause_toggle | (osd_s2 & pause_osd_en);
    end
  end

  assign core.inp0  = pad_q;
  assign core.inp1  = pad_q;
  assign core.inp2  = inp2_q;
  assign core.pause = pause_q;

`ifdef SYS1_PAUSE_DIM_EN
  logic [31:0] timer_q;
  logic        toggle_d, dim_q;

  // The first toggled cycle only arms the timer, so dim rises DIM_CYCLES+2
  // cycles after the toggle and falls 2 cycles after it clears.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      timer_q  <= '0;
      toggle_d <= 1'b0;
      dim_q    <= 1'b0;
    end else begin
      toggle_d <= pause_toggle;
      if (!pause_toggle)                          timer_q <= '0;
      else if (toggle_d && timer_q < DIM_CYCLES)  timer_q <= timer_q + 32'd1;
      dim_q    <= (timer_q >= DIM_CYCLES);
    end
  end

  assign core.dim = dim_q;
`else
  logic unused_dim;
  assign unused_dim = ^DIM_CYCLES;
  assign core.dim   = 1'b0;
`endif

  logic unused_bits;
  assign unused_bits = ^{joy_s2[15:13], joy_s2[8:7], joy1_s2[15:9], joy2_s2[15:4],
                         sysmode[7:6], sysmode[4], sysmode[2:0]};

endmodule
